// File: rtl/mic1_mem_responder.sv
// MIC-1 memory responder: word data array on MAR/MDR, byte program array on PC/MBR,
// one-cycle read latency. Optional range checking under `MIC1_MEM_RANGE_CHECK_EN.
module mic1_mem_responder #(
  parameter int DATA_AW = 10,
  parameter int PROG_AW = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd,
  input  logic               wr,
  input  logic               fetch,
  input  logic [31:0]        mar,
  input  logic [31:0]        mdr_wdata,
  input  logic [31:0]        pc,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [7:0]         prog_wdata,
  output logic [31:0]        mdr_rdata,
  output logic               mdr_valid,
  output logic [7:0]         mbr_data,
  output logic               mbr_valid,
  output logic               err
);

  logic [31:0] dmem_q [2**DATA_AW];
  logic [7:0]  pmem_q [2**PROG_AW];

  logic [DATA_AW-1:0] d_idx;
  logic [PROG_AW-1:0] p_idx;
  logic               mar_oor, pc_oor;

  assign d_idx = mar[DATA_AW-1:0];
  assign p_idx = pc[PROG_AW-1:0];

`ifdef MIC1_MEM_RANGE_CHECK_EN
  assign mar_oor = |mar[31:DATA_AW];
  assign pc_oor  = |pc[31:PROG_AW];
`else
  // High address bits are ignored: accesses wrap modulo the array depth.
  logic unused_hi_addr;
  assign unused_hi_addr = ^{mar[31:DATA_AW], pc[31:PROG_AW]};
  assign mar_oor = 1'b0;
  assign pc_oor  = 1'b0;
`endif

  logic [31:0] mdr_rdata_d, mdr_rdata_q;
  logic        mdr_valid_d, mdr_valid_q;
  logic [7:0]  mbr_data_d,  mbr_data_q;
  logic        mbr_valid_d, mbr_valid_q;
  logic        err_d,       err_q;
  logic        dmem_we, rd_ok;

  always_comb begin
    dmem_we     = wr & ~reset & ~mar_oor;
    rd_ok       = rd & ~wr & ~reset;
    mdr_valid_d = rd_ok;
    mdr_rdata_d = mdr_rdata_q;
    mbr_valid_d = fetch & ~reset;
    mbr_data_d  = mbr_data_q;
    err_d       = err_q | (rd & wr) | ((rd | wr) & mar_oor) | (fetch & pc_oor);
    if (rd_ok)
      mdr_rdata_d = mar_oor ? 32'h0 : dmem_q[d_idx];
    // Array reads happen before this edge's loader write lands: read-first.
    if (fetch)
      mbr_data_d = pc_oor ? 8'h00 : pmem_q[p_idx];
  end

  always_ff @(posedge clock) begin
    if (dmem_we) dmem_q[d_idx] <= mdr_wdata;
    if (prog_we) pmem_q[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mdr_rdata_q <= '0;
      mdr_valid_q <= 1'b0;
      mbr_data_q  <= '0;
      mbr_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mdr_rdata_q <= mdr_rdata_d;
      mdr_valid_q <= mdr_valid_d;
      mbr_data_q  <= mbr_data_d;
      mbr_valid_q <= mbr_valid_d;
      err_q       <= err_d;
    end
  end

  // Outputs are forced low while reset is high so a pending result never pulses.
  assign mdr_rdata = reset ? 32'h0 : mdr_rdata_q;
  assign mdr_valid = mdr_valid_q & ~reset;
  assign mbr_data  = reset ? 8'h00 : mbr_data_q;
  assign mbr_valid = mbr_valid_q & ~reset;
  assign err       = err_q & ~reset;

endmodule

// File: tb/tb_mic1_mem_responder.sv
// Directed self-checking bench for mic1_mem_responder; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_mic1_mem_responder;

  logic        clock = 1'b0;
  logic        reset, rd, wr, fetch, prog_we;
  logic [31:0] mar, mdr_wdata, pc;
  logic [9:0]  prog_addr;
  logic [7:0]  prog_wdata;
  logic [31:0] mdr_rdata;
  logic        mdr_valid, mbr_valid, err;
  logic [7:0]  mbr_data;

  int n_chk = 0;
  int n_fail = 0;

  mic1_mem_responder #(.DATA_AW(10), .PROG_AW(10)) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .mdr_wdata(mdr_wdata), .pc(pc), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .mdr_rdata(mdr_rdata),
    .mdr_valid(mdr_valid), .mbr_data(mbr_data), .mbr_valid(mbr_valid), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] prog_init [4];

  initial begin
    prog_init[0] = 8'h10; prog_init[1] = 8'h59; prog_init[2] = 8'hA7; prog_init[3] = 8'hCA;
    reset = 1'b1; rd = 0; wr = 0; fetch = 0; prog_we = 0;
    mar = 0; mdr_wdata = 0; pc = 0; prog_addr = 0; prog_wdata = 0;
    cyc(); cyc();
    chk("rst_mdr_valid", mdr_valid, 0);
    chk("rst_mdr_rdata", mdr_rdata, 0);
    chk("rst_mbr_valid", mbr_valid, 0);
    chk("rst_mbr_data", mbr_data, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_valid", mdr_valid, 0);

    // 1: write then read
    wr = 1; mar = 5; mdr_wdata = 32'hDEADBEEF;
    cyc();
    wr = 0;
    chk("wr_no_valid", mdr_valid, 0);
    rd = 1; mar = 5;
    cyc();
    rd = 0;
    chk("t1_valid", mdr_valid, 1);
    chk("t1_rdata", mdr_rdata, 32'hDEADBEEF);
    cyc();
    chk("t1_pulse_once", mdr_valid, 0);
    chk("t1_hold", mdr_rdata, 32'hDEADBEEF);

    // back-to-back reads
    wr = 1; mar = 10; mdr_wdata = 32'hAAAA_0001; cyc();
    mar = 11; mdr_wdata = 32'hBBBB_0002; cyc();
    wr = 0; rd = 1; mar = 10; cyc();
    chk("b2b0_valid", mdr_valid, 1);
    chk("b2b0_rdata", mdr_rdata, 32'hAAAA_0001);
    mar = 11; cyc();
    rd = 0;
    chk("b2b1_valid", mdr_valid, 1);
    chk("b2b1_rdata", mdr_rdata, 32'hBBBB_0002);

    // 2: program load and fetch stream
    for (int i = 0; i < 4; i++) begin
      prog_we = 1; prog_addr = 10'(i); prog_wdata = prog_init[i];
      cyc();
    end
    prog_we = 0;
    for (int i = 0; i < 4; i++) begin
      fetch = 1; pc = i;
      cyc();
      chk($sformatf("fetch%0d_valid", i), mbr_valid, 1);
      chk($sformatf("fetch%0d_data", i), mbr_data, prog_init[i]);
    end
    fetch = 0;
    cyc();
    chk("fetch_end_valid", mbr_valid, 0);
    chk("err_clean", err, 0);

    // 3: rd+wr collision
    rd = 1; wr = 1; mar = 7; mdr_wdata = 32'h33;
    cyc();
    rd = 0; wr = 0;
    chk("coll_no_valid", mdr_valid, 0);
    chk("coll_err", err, 1);
    chk("coll_rdata_hold", mdr_rdata, 32'hBBBB_0002);
    rd = 1; mar = 7;
    cyc();
    rd = 0;
    chk("coll_readback", mdr_rdata, 32'h33);

    // 4: address beyond array depth
    wr = 1; mar = 0; mdr_wdata = 32'h1234_5678; cyc();
    wr = 0; rd = 1; mar = 32'h0000_0400; fetch = 1; pc = 32'h0000_0400;
    cyc();
    rd = 0; fetch = 0;
    chk("oor_rd_valid", mdr_valid, 1);
    chk("oor_fetch_valid", mbr_valid, 1);
`ifdef MIC1_MEM_RANGE_CHECK_EN
    chk("oor_rd_data", mdr_rdata, 32'h0);
    chk("oor_fetch_data", mbr_data, 8'h00);
`else
    chk("wrap_rd_data", mdr_rdata, 32'h1234_5678);
    chk("wrap_fetch_data", mbr_data, 8'h10);
`endif
    chk("oor_err", err, 1);

    // 5: reset while a read result is pending
    rd = 1; mar = 5;
    cyc();
    reset = 1;
    wr = 1; mar = 5; mdr_wdata = 32'h0;
    #1;
    chk("rst_pend_valid", mdr_valid, 0);
    chk("rst_pend_rdata", mdr_rdata, 0);
    chk("rst_pend_err", err, 0);
    cyc();
    chk("rst_hold_valid", mdr_valid, 0);
    reset = 0; rd = 0; wr = 0;
    cyc();
    chk("rst_after_valid", mdr_valid, 0);
    chk("rst_after_rdata", mdr_rdata, 0);
    chk("rst_after_err", err, 0);
    chk("rst_after_mbr", mbr_data, 0);
    rd = 1; mar = 5;
    cyc();
    rd = 0;
    chk("rst_wr_dropped", mdr_rdata, 32'hDEADBEEF);

    // 6: loader write and fetch to same byte, same cycle
    prog_we = 1; prog_addr = 2; prog_wdata = 8'hFF; fetch = 1; pc = 2;
    cyc();
    prog_we = 0;
    chk("rf_old", mbr_data, 8'hA7);
    cyc();
    fetch = 0;
    chk("rf_new", mbr_data, 8'hFF);
    chk("loader_no_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
